// File: rtl/dmem_access_unit_if.sv
// CPU-side request/response bus and word-wide data-memory port of the load/store unit.
// The unit takes the slave modport; the CPU/memory side (or a bench) takes the master modport.
interface dmem_access_unit_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic [2:0]        op;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              dm_wena;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_idata;
  logic [31:0]       dm_odata;

  modport slave (
    input  req, op, addr, wdata, dm_odata,
    output ready, done, err, rdata, dm_wena, dm_addr, dm_idata
  );

  modport master (
    output req, op, addr, wdata, dm_odata,
    input  ready, done, err, rdata, dm_wena, dm_addr, dm_idata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store front end for a word-wide data memory: sub-word loads with extension,
// sub-word stores by read-modify-write, misaligned requests flagged without a memory write.
module dmem_access_unit #(
  parameter int   ADDR_W   = 12,
  parameter logic MEM_LOAD = 1'b0,
  parameter logic MEM_SAVE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  dmem_access_unit_if.slave  bus
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
    logic m;
    case (op)
      OP_LW, OP_SW:         m = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: m = a[0];
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = a[1] ? w[31:16] : w[15:0];
    b = w[{a, 3'b000} +: 8];
    case (op)
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] w, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    case (op)
      OP_SB:   r[{a, 3'b000} +: 8]     = wd[7:0];
      OP_SH:   r[{a[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mis_q, mis_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, done_q, err_q;
  logic              unused_addr_s;

  assign unused_addr_s = ^bus.addr[31:ADDR_W];

  // Next-state, request capture, load extraction and merge-buffer capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          op_d    = bus.op;
          addr_d  = bus.addr[ADDR_W-1:0];
          wdata_d = bus.wdata;
          mis_d   = is_misaligned(bus.op, bus.addr[1:0]);
          if (mis_d) begin
            state_d = RESP;
          end else if (bus.op <= OP_LBU) begin
            state_d = LOAD;
          end else if (bus.op == OP_SW) begin
            state_d = STORE;
          end else begin
            state_d = RMW_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        rdata_d = load_extend(op_q, addr_q[1:0], bus.dm_odata);
        state_d = RESP;
      end
      STORE:   state_d = RESP;
      RMW_RD: begin
        merge_d = bus.dm_odata;
        state_d = RMW_WR;
      end
      RMW_WR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      mis_q   <= 1'b0;
      merge_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      ready_q <= (state_d == IDLE);
      done_q  <= (state_d == RESP);
      err_q   <= (state_d == RESP) && mis_d;
    end
  end

  // Memory-side drive decoded from registered state so a reset kills a write in the same cycle
  always_comb begin
    bus.dm_wena  = ((state_q == STORE) || (state_q == RMW_WR)) ? MEM_SAVE : MEM_LOAD;
    bus.dm_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    bus.dm_idata = 32'h0000_0000;
    case (state_q)
      STORE:   bus.dm_idata = wdata_q;
      RMW_WR:  bus.dm_idata = store_merge(op_q, addr_q[1:0], merge_q, wdata_q);
      default: bus.dm_idata = 32'h0000_0000;
    endcase
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural word memory and an expected-response queue.
module tb_dmem_access_unit;

  localparam int ADDR_W = 12;

  typedef struct {
    logic [31:0] lat;
    logic [31:0] err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst;
  logic [31:0] mem [0:1023];
  int   wr_cnt;
  int   total;
  int   passed;
  exp_t sb_q[$];

  dmem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_access_unit #(.ADDR_W(ADDR_W), .MEM_LOAD(1'b0), .MEM_SAVE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.dm_odata = mem[bus.dm_addr[ADDR_W-1:2]];

  always @(posedge clk) begin
    if (bus.dm_wena === 1'b1) begin
      mem[bus.dm_addr[ADDR_W-1:2]] <= bus.dm_idata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic do_req(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] wd, input int lat, input logic e,
                        input logic [31:0] rd);
    exp_t x;
    int   cyc;
    x.lat = 32'(lat);
    x.err = {31'd0, e};
    x.rdata = rd;
    sb_q.push_back(x);
    bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    x = sb_q.pop_front();
    check({tag, " latency"}, 32'(cyc), x.lat);
    check({tag, " err"}, {31'd0, bus.err}, x.err);
    check({tag, " rdata"}, bus.rdata, x.rdata);
    @(negedge clk);
    check({tag, " ready after"}, {31'd0, bus.ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    int wr_base;
    total = 0; passed = 0; wr_cnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h80 >> 2] = 32'h8001_FF7F;
    mem[32'h20 >> 2] = 32'h1122_3344;
    bus.req = 1'b0; bus.op = 3'b000; bus.addr = 32'h0; bus.wdata = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset ready", {31'd0, bus.ready}, 32'd1);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset err", {31'd0, bus.err}, 32'd0);
    check("reset rdata", bus.rdata, 32'h0);
    check("reset dm_wena", {31'd0, bus.dm_wena}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle no write", 32'(wr_cnt), 32'd0);
    check("idle ready", {31'd0, bus.ready}, 32'd1);

    do_req("SW 0x10", 3'b101, 32'h10, 32'hDEAD_BEEF, 2, 1'b0, 32'h0);
    check("mem 0x10", mem[4], 32'hDEAD_BEEF);
    do_req("LW 0x10", 3'b000, 32'h10, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);

    do_req("LB 0x81", 3'b011, 32'h81, 32'h0, 2, 1'b0, 32'hFFFF_FFFF);
    do_req("LBU 0x81", 3'b100, 32'h81, 32'h0, 2, 1'b0, 32'h0000_00FF);
    do_req("LH 0x82", 3'b001, 32'h82, 32'h0, 2, 1'b0, 32'hFFFF_8001);
    do_req("LHU 0x82", 3'b010, 32'h82, 32'h0, 2, 1'b0, 32'h0000_8001);
    do_req("LB 0x80", 3'b011, 32'h80, 32'h0, 2, 1'b0, 32'h0000_007F);

    do_req("SB 0x22", 3'b111, 32'h22, 32'h0000_00AA, 3, 1'b0, 32'h0000_007F);
    check("mem 0x20 after SB", mem[8], 32'h11AA_3344);
    do_req("SH 0x20", 3'b110, 32'h20, 32'h0000_5566, 3, 1'b0, 32'h0000_007F);
    check("mem 0x20 after SH", mem[8], 32'h11AA_5566);

    wr_base = wr_cnt;
    do_req("LW 0x13 misaligned", 3'b000, 32'h13, 32'h0, 1, 1'b1, 32'h0000_007F);
    do_req("SH 0x21 misaligned", 3'b110, 32'h21, 32'h0000_FFFF, 1, 1'b1, 32'h0000_007F);
    do_req("SW 0x22 misaligned", 3'b101, 32'h22, 32'hFFFF_FFFF, 1, 1'b1, 32'h0000_007F);
    check("misaligned no write", 32'(wr_cnt), 32'(wr_base));
    check("misaligned mem 0x20", mem[8], 32'h11AA_5566);
    check("misaligned mem 0x10", mem[4], 32'hDEAD_BEEF);

    // req stays high through an SB; the following LW must wait for ready
    bus.req = 1'b1; bus.op = 3'b111; bus.addr = 32'h83; bus.wdata = 32'h0000_005A;
    @(posedge clk);
    @(negedge clk);
    bus.op = 3'b000; bus.addr = 32'h10; bus.wdata = 32'h0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("busy SB latency", 32'(cyc), 32'd3);
    @(negedge clk);
    check("busy ready after SB", {31'd0, bus.ready}, 32'd1);
    @(negedge clk);
    bus.req = 1'b0;
    check("busy LW accepted", {31'd0, bus.ready}, 32'd0);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("busy LW latency", 32'(cyc), 32'd2);
    check("busy LW rdata", bus.rdata, 32'hDEAD_BEEF);
    check("busy SB mem 0x80", mem[32], 32'h5A01_FF7F);

    @(negedge clk);
    wr_base = wr_cnt;
    bus.req = 1'b1; bus.op = 3'b111; bus.addr = 32'h21; bus.wdata = 32'h0000_0000;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    rst = 1'b1;
    #1;
    check("rst mid dm_wena", {31'd0, bus.dm_wena}, 32'd0);
    check("rst mid ready", {31'd0, bus.ready}, 32'd1);
    check("rst mid done", {31'd0, bus.done}, 32'd0);
    check("rst mid rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst mid no write", 32'(wr_cnt), 32'(wr_base));
    check("rst mid mem 0x20", mem[8], 32'h11AA_5566);
    check("rst mid idle ready", {31'd0, bus.ready}, 32'd1);
    check("rst mid idle done", {31'd0, bus.done}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Load/store front end that sits directly upstream of the word-wide data memory.
- Accepts one CPU memory request at a time and translates LW/LH/LHU/LB/LBU/SW/SH/SB into word-aligned memory accesses.
- Sub-word stores are done as read-modify-write, because the data memory only writes full 32-bit words.
- Loads are sign- or zero-extended, and misaligned accesses are flagged without touching memory.

Parameters:
- ADDR_W, 12, number of low byte-address bits forwarded to data memory; upper request address bits are ignored.
- MEM_LOAD, 1'b0, data-memory write-enable value meaning read.
- MEM_SAVE, 1'b1, data-memory write-enable value meaning write.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req  in  1  request valid; sampled only while ready=1.
- op  in  3  request op: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- addr  in  32  byte address of the request.
- wdata  in  32  store data; SH uses [15:0], SB uses [7:0].
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  misalignment flag; valid with done.
- rdata  out  32  load result, extended; held until the next load completes.
- dm_wena  out  1  data-memory write enable (MEM_LOAD/MEM_SAVE).
- dm_addr  out  ADDR_W  word-aligned byte address to data memory.
- dm_idata  out  32  word to be written.
- dm_odata  in  32  word read combinationally from data memory.

Behaviour:
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- Reset values (rst=1, asynchronous): state=IDLE, ready=1, done=0, err=0, rdata=0, dm_wena=MEM_LOAD, dm_addr=0, dm_idata=0, all captured request registers 0.
- Accept: in IDLE with req=1 at an edge, op/addr/wdata are registered.
  - req is ignored in any other state; there is no queue.
  - Next state: misaligned → RESP with err=1; load → LOAD; SW → STORE; SH/SB → RMW_RD.
- Misalignment:
  - LW/SW require addr[1:0]=00.
  - LH/LHU/SH require addr[0]=0.
  - Byte ops are never misaligned.
  - A misaligned request never asserts dm_wena=MEM_SAVE, and rdata is unchanged.
- dm_addr = {captured addr[ADDR_W-1:2], 2'b00} in every non-IDLE state.
- dm_wena = MEM_SAVE only in STORE and RMW_WR; MEM_LOAD everywhere else.
- LOAD (1 cycle): at exit, select the lane from dm_odata, little-endian (byte k = dm_odata[8k+7:8k], k=addr[1:0]; halfword lane = addr[1]).
  - Extend: LH/LB sign-extend, LHU/LBU zero-extend.
  - Register into rdata, then go to RESP.
- STORE (1 cycle): dm_idata = captured wdata; go to RESP.
- RMW_RD (1 cycle): register dm_odata into a merge buffer; go to RMW_WR.
- RMW_WR (1 cycle): dm_idata = merge buffer with the selected byte/halfword lane replaced by wdata[7:0] or wdata[15:0]; other lanes preserved; go to RESP.
- RESP (1 cycle): done=1, err as captured, ready=0; go to IDLE.
  - A new request can be accepted in the cycle after done.
- Latency, counted as cycles from the accepting edge to the done cycle:
  - misaligned: 1
  - load / SW: 2
  - SH/SB: 3
- Reset mid-operation: return to IDLE immediately; dm_wena drops to MEM_LOAD in the same cycle; no partial or later write is issued.
- done and err are never asserted outside RESP.

Test Plan:
- Reset then idle: rst pulse → ready=1, done=0, err=0, rdata=0, dm_wena=0; no write for 20 cycles with req=0.
- SW/LW round trip: SW addr=0x10 wdata=0xDEADBEEF → done 2 cycles after accept, memory word 0x10=0xDEADBEEF; then LW 0x10 → rdata=0xDEADBEEF.
- Sub-word loads on word 0x80=0x8001FF7F:
  - LB 0x81 → 0xFFFFFFFF
  - LBU 0x81 → 0x000000FF
  - LH 0x82 → 0xFFFF8001
  - LHU 0x82 → 0x00008001
  - LB 0x80 → 0x0000007F
- Read-modify-write on word 0x20=0x11223344:
  - SB 0x22 wdata=0xAA → word 0x11AA3344, done 3 cycles after accept.
  - Then SH 0x20 wdata=0x5566 → word 0x11AA5566.
- Misaligned: LW 0x13, SH 0x21 and SW 0x22 → each gives done+err 1 cycle after accept; dm_wena never 1; rdata and memory unchanged.
- Busy/reset corner:
  - req held high during an SB is ignored until ready returns; it is accepted the cycle after done.
  - rst asserted during RMW_RD → no write to memory; state IDLE; outputs at reset values.
